// File: rtl/sound_wave_ram_ctrl_pkg.sv
// Shared APU definitions for the channel-3 wave RAM: geometry, bus defaults,
// controller state encoding and the debug view of the controller.
package sound_wave_ram_ctrl_pkg;

  localparam int          WAVE_DEPTH       = 16;
  localparam int          IDX_W            = 4;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'hFF;
  localparam logic [15:0] WAVE_BASE_ADDR   = 16'hFF30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [IDX_W-1:0] win_cnt;
    logic [IDX_W-1:0] last_idx;
  } dbg_t;

endpackage

// File: rtl/sound_wave_ram_ctrl_if.sv
// CPU bus port and channel-3 fetch port of the wave RAM controller.
interface sound_wave_ram_ctrl_if;
  import sound_wave_ram_ctrl_pkg::*;

  // cpu_rd, cpu_wr and ch_fetch are one-cycle request pulses that are always
  // accepted (no ready); cpu_ack and ch_valid answer exactly one cycle later.
  logic [IDX_W-1:0] cpu_a;
  logic [7:0]       cpu_din;
  logic             cpu_wr;
  logic             cpu_rd;
  logic [7:0]       cpu_dout;
  logic             cpu_ack;
  logic             ch_active;
  logic             ch_fetch;
  logic [IDX_W-1:0] ch_a;
  logic [7:0]       ch_d;
  logic             ch_valid;

  modport master (
    output cpu_a, cpu_din, cpu_wr, cpu_rd, ch_active, ch_fetch, ch_a,
    input  cpu_dout, cpu_ack, ch_d, ch_valid
  );

  modport slave (
    input  cpu_a, cpu_din, cpu_wr, cpu_rd, ch_active, ch_fetch, ch_a,
    output cpu_dout, cpu_ack, ch_d, ch_valid
  );

endinterface

// File: rtl/sound_wave_ram_ctrl_ram.sv
// 16x8 wave RAM register file: one synchronous write port, two combinational
// read ports (CPU side and channel side), cleared by synchronous reset.
module wave_ram_16x8
  import sound_wave_ram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  logic [7:0]       wd,
  input  logic [IDX_W-1:0] ra_cpu,
  output logic [7:0]       rd_cpu,
  input  logic [IDX_W-1:0] ra_ch,
  output logic [7:0]       rd_ch
);

  logic [7:0] mem [WAVE_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WAVE_DEPTH; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // Reads see pre-write contents, giving read-before-write in a shared cycle.
  assign rd_cpu = mem[ra_cpu];
  assign rd_ch  = mem[ra_ch];

endmodule

// File: rtl/sound_wave_ram_ctrl.sv
// Channel-3 wave RAM controller: CPU has free access while the channel is off,
// and while playing only reaches the last fetched byte inside a short window.
module sound_wave_ram_ctrl
  import sound_wave_ram_ctrl_pkg::*;
#(
  parameter int         ACCESS_WINDOW = 2,
  parameter logic [7:0] OPEN_BUS      = OPEN_BUS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  sound_wave_ram_ctrl_if.slave  bus,
  output dbg_t                  dbg
);

  localparam logic [IDX_W-1:0] WIN_INIT = IDX_W'(ACCESS_WINDOW);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             fetch;
  logic             ram_we;
  logic [IDX_W-1:0] cpu_idx;
  logic [7:0]       rd_cpu, rd_ch;
  logic [7:0]       cpu_dout_q, ch_d_q;
  logic             cpu_ack_q, ch_valid_q;

  // The cycle ch_active rises the state is still IDLE, so that fetch is dropped.
  always_comb begin
    fetch   = bus.ch_fetch && bus.ch_active && (state_q != ST_IDLE);
    cpu_idx = (state_q == ST_WIN) ? last_idx_q : bus.cpu_a;
    ram_we  = bus.cpu_wr && (state_q != ST_PLAY);
  end

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    last_idx_d = last_idx_q;
    if (!bus.ch_active) begin
      state_d   = ST_IDLE;
      win_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_PLAY;
      win_cnt_d  = '0;
      last_idx_d = '0;
    end else if (fetch) begin
      state_d    = ST_WIN;
      win_cnt_d  = WIN_INIT;
      last_idx_d = bus.ch_a;
    end else if (win_cnt_q != '0) begin
      win_cnt_d = win_cnt_q - 1'b1;
      state_d   = (win_cnt_q == 1) ? ST_PLAY : ST_WIN;
    end else begin
      state_d = ST_PLAY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

  // A write in the same cycle as a read wins; the read is dropped and dout holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_dout_q <= 8'h00;
      cpu_ack_q  <= 1'b0;
      ch_d_q     <= 8'h00;
      ch_valid_q <= 1'b0;
    end else begin
      cpu_ack_q  <= bus.cpu_rd || bus.cpu_wr;
      ch_valid_q <= fetch;
      if (fetch) ch_d_q <= rd_ch;
      if (bus.cpu_rd && !bus.cpu_wr)
        cpu_dout_q <= (state_q == ST_PLAY) ? OPEN_BUS : rd_cpu;
    end
  end

  wave_ram_16x8 u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (ram_we),
    .wa     (cpu_idx),
    .wd     (bus.cpu_din),
    .ra_cpu (cpu_idx),
    .rd_cpu (rd_cpu),
    .ra_ch  (bus.ch_a),
    .rd_ch  (rd_ch)
  );

  assign bus.cpu_dout = cpu_dout_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.ch_d     = ch_d_q;
  assign bus.ch_valid = ch_valid_q;
  assign dbg          = {state_q, win_cnt_q, last_idx_q};

endmodule

// File: doc/sound_wave_ram_ctrl.md
Name: sound_wave_ram_ctrl

Overview:
- Owns the 16x8 channel-3 wave RAM (FF30–FF3F).
- Arbitrates it between the CPU bus port and the channel-3 sample fetch port.
- CPU has free access while channel 3 is off. While it plays, CPU access is redirected to the byte last fetched by the channel, and only inside a short window after each fetch (DMG behaviour).
- Sits between the APU register decoder and the wave player, and supplies the player's sample byte.

Parameters:
- ACCESS_WINDOW, 2: cycles after a channel fetch during which a CPU access hits the fetched byte; range 1..15.
- OPEN_BUS, 8'hFF: value returned to a CPU read that falls outside the window while playing.

Ports:
- clk  in  1  main CPU clock
- rst  in  1  synchronous reset, active-high
- cpu_a  in  4  wave RAM byte index (address bits 3:0)
- cpu_din  in  8  CPU write data
- cpu_wr  in  1  CPU write strobe, one-cycle pulse
- cpu_rd  in  1  CPU read strobe, one-cycle pulse
- cpu_dout  out  8  CPU read data, registered
- cpu_ack  out  1  one-cycle pulse, access completed
- ch_active  in  1  channel 3 DAC on and playing
- ch_fetch  in  1  one-cycle pulse, channel requests byte ch_a
- ch_a  in  4  channel byte index (pointer[4:1])
- ch_d  out  8  latched sample byte for the player
- ch_valid  out  1  one-cycle pulse, ch_d updated

Behaviour:
- Reset (rst high at a clk edge):
  - All RAM bytes = 8'h00; cpu_dout = 8'h00; ch_d = 8'h00.
  - cpu_ack = 0; ch_valid = 0; last_idx = 0; win_cnt = 0; state = IDLE.
  - Reset mid-operation aborts any pending ack or valid pulse.
- States:
  - IDLE: ch_active = 0.
  - PLAY: ch_active = 1, win_cnt = 0.
  - WIN: ch_active = 1, win_cnt != 0.
- Transitions:
  - IDLE -> PLAY when ch_active rises. last_idx <= 0 and win_cnt <= 0 on the rise.
  - PLAY -> WIN on ch_fetch.
  - WIN -> PLAY when win_cnt decrements to 0.
  - WIN -> WIN on a new ch_fetch; win_cnt reloads.
  - Any state -> IDLE when ch_active = 0. win_cnt is cleared.
- Channel fetch (cycle n, ch_active = 1):
  - RAM[ch_a] is read in cycle n; ch_d and ch_valid are updated at n+1.
  - last_idx <= ch_a; win_cnt <= ACCESS_WINDOW.
  - ch_fetch is ignored in IDLE: no ch_valid, ch_d holds.
- win_cnt decrements by 1 per cycle when non-zero and no fetch occurs; it saturates at 0.
- CPU access (cycle n): cpu_ack = 1 at n+1 for exactly one cycle, in every state.
  - IDLE: effective index = cpu_a. Read: cpu_dout <= RAM[cpu_a]. Write: RAM[cpu_a] <= cpu_din.
  - WIN: effective index = last_idx, and cpu_a is ignored. Reads and writes target RAM[last_idx].
  - PLAY: read returns cpu_dout <= OPEN_BUS; write is dropped.
- Simultaneous events:
  - cpu_rd and cpu_wr in the same cycle: the write is performed, no read occurs, cpu_dout holds, one ack.
  - ch_fetch and cpu_wr in the same cycle: read-before-write. ch_d gets the old byte; the write lands per the state at cycle n, before last_idx and win_cnt update.
  - ch_fetch and cpu_rd in the same cycle: the read uses the state at cycle n (pre-fetch last_idx and window).
  - ch_active falling in the same cycle as a CPU access: the access is evaluated with the state at cycle n.
- Index arithmetic: 4-bit. Indices wrap mod 16; no out-of-range access exists.
- Latency: fixed at 1 cycle for both ports. There is no back-pressure; the CPU never stalls.

Decomposition:
- Shared APU package holds:
  - WAVE_DEPTH = 16.
  - Default OPEN_BUS = 8'hFF.
  - 2-bit state encoding: IDLE = 0, PLAY = 1, WIN = 2.
  - Wave RAM base address 16'hFF30, for the decoder.
- One sub-module, wave_ram_16x8:
  - 16x8 register file, one synchronous write port, two combinational read ports (CPU, channel).
  - Synchronous clear on rst.
- The controller holds the FSM, win_cnt, last_idx and the output registers.

Test Plan:
- Reset, then read each index in IDLE: every cpu_dout = 8'h00, with cpu_ack 1 cycle after each cpu_rd.
- IDLE: write 8'hA5 to index 3, then read index 3 -> cpu_dout = 8'hA5 one cycle after cpu_rd; index 4 still reads 8'h00.
- Fetch and window hit: set ch_active = 1, fetch ch_a = 3, then in the next cycle cpu_rd with cpu_a = 9 -> cpu_dout = 8'hA5. Write 8'h3C in the window -> RAM[3] = 8'h3C and RAM[9] unchanged.
- Outside the window (ACCESS_WINDOW = 2): fetch, wait 3 cycles, cpu_rd -> cpu_dout = 8'hFF; cpu_wr of 8'h11 -> RAM unchanged (check after ch_active = 0).
- Read-before-write: with RAM[5] = 8'h12, ch_fetch ch_a = 5 in the same cycle as a windowed write of 8'h77 whose last_idx = 5 -> ch_d = 8'h12 and ch_valid pulses; a later fetch of 5 gives ch_d = 8'h77.
- Reset mid-window: assert rst 1 cycle after ch_fetch -> next cycle ch_valid = 0, win_cnt = 0, RAM cleared, and an IDLE read returns 8'h00.
